multicycle_ctrl: RTL and testbench

- Main control FSM for the multicycle RV32I core.
- Sequences the fetch/PC stage: fetch strobe, PC update, next-PC source select, memory-hold signals.
- Also sequences the instruction/data memory request handshakes and register-file write enable.
- Exactly one instruction in flight; PC advances once per retired instruction.

---
 rtl/ctrl_pkg.sv | 65 ++++++
 rtl/ctrl_decode.sv | 34 +++
 rtl/multicycle_ctrl.sv | 198 +++++++++++++++++++
 tb/tb_multicycle_ctrl.sv | 293 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ctrl_pkg.sv
// Shared types and encodings for the multicycle RV32I control FSM.
// Used by ctrl_decode and multicycle_ctrl (optional counters: CTRL_PERF_EN).
package ctrl_pkg;

   localparam int unsigned OPCODE_W   = 7;
   localparam int unsigned PC_SEL_W   = 3;
   localparam int unsigned WAIT_CNT_W = 8;
   localparam int unsigned PERF_W     = 32;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_FETCH,
      ST_DECODE,
      ST_EXEC,
      ST_MEM,
      ST_WB,
      ST_HALT
   } state_e;

   typedef enum logic [3:0] {
      CLS_NONE,
      CLS_LOAD,
      CLS_STORE,
      CLS_BRANCH,
      CLS_JAL,
      CLS_JALR,
      CLS_OP,
      CLS_OPIMM,
      CLS_LUI,
      CLS_AUIPC,
      CLS_SYSTEM,
      CLS_ILLEGAL
   } iclass_e;

   // Decoded instruction summary, latched in DECODE before the fetch stage drops instr.
   typedef struct packed {
      iclass_e cls;
      logic    rf_we;
   } dec_t;

   localparam logic [OPCODE_W-1:0] OPC_LOAD   = 7'b0000011;
   localparam logic [OPCODE_W-1:0] OPC_STORE  = 7'b0100011;
   localparam logic [OPCODE_W-1:0] OPC_BRANCH = 7'b1100011;
   localparam logic [OPCODE_W-1:0] OPC_JAL    = 7'b1101111;
   localparam logic [OPCODE_W-1:0] OPC_JALR   = 7'b1100111;
   localparam logic [OPCODE_W-1:0] OPC_OP     = 7'b0110011;
   localparam logic [OPCODE_W-1:0] OPC_OPIMM  = 7'b0010011;
   localparam logic [OPCODE_W-1:0] OPC_LUI    = 7'b0110111;
   localparam logic [OPCODE_W-1:0] OPC_AUIPC  = 7'b0010111;
   localparam logic [OPCODE_W-1:0] OPC_SYSTEM = 7'b1110011;

   localparam logic [PC_SEL_W-1:0] PC_SEL_DEF  = 3'b000;
   localparam logic [PC_SEL_W-1:0] PC_SEL_BRA  = 3'b001;
   localparam logic [PC_SEL_W-1:0] PC_SEL_JALR = 3'b010;
   localparam logic [PC_SEL_W-1:0] PC_SEL_JAL  = 3'b100;

   function automatic logic is_mem_class(input iclass_e cls);
      return (cls == CLS_LOAD) || (cls == CLS_STORE);
   endfunction

   function automatic logic is_halt_class(input iclass_e cls);
      return (cls == CLS_SYSTEM) || (cls == CLS_ILLEGAL);
   endfunction

endpackage

// File: rtl/ctrl_decode.sv
// Combinational opcode classifier: instruction class plus register-file write requirement.
module ctrl_decode
   import ctrl_pkg::*;
(
   input  logic [OPCODE_W-1:0] opcode,
   output dec_t                dec
);

   always_comb begin
      dec.cls   = CLS_ILLEGAL;
      dec.rf_we = 1'b0;

      case (opcode)
         OPC_LOAD:   dec.cls = CLS_LOAD;
         OPC_STORE:  dec.cls = CLS_STORE;
         OPC_BRANCH: dec.cls = CLS_BRANCH;
         OPC_JAL:    dec.cls = CLS_JAL;
         OPC_JALR:   dec.cls = CLS_JALR;
         OPC_OP:     dec.cls = CLS_OP;
         OPC_OPIMM:  dec.cls = CLS_OPIMM;
         OPC_LUI:    dec.cls = CLS_LUI;
         OPC_AUIPC:  dec.cls = CLS_AUIPC;
         OPC_SYSTEM: dec.cls = CLS_SYSTEM;
         default:    dec.cls = CLS_ILLEGAL;
      endcase

      // Only instructions producing a rd result write the register file.
      case (dec.cls)
         CLS_LOAD, CLS_OP, CLS_OPIMM, CLS_LUI, CLS_AUIPC, CLS_JAL, CLS_JALR: dec.rf_we = 1'b1;
         default: dec.rf_we = 1'b0;
      endcase
   end

endmodule

// File: rtl/multicycle_ctrl.sv
// Main control FSM of the multicycle RV32I core: fetch/decode/exec/mem/writeback sequencing.
// Define CTRL_PERF_EN to build the cycle and retired-instruction counters.
module multicycle_ctrl
   import ctrl_pkg::*;
#(
   parameter int unsigned MEM_TIMEOUT = 255,
   parameter int unsigned RESET_HOLD  = 2
) (
   input  logic                clk,
   input  logic                reset,
   input  logic [31:0]         instr,
   input  logic                branch_taken,
   input  logic                imem_valid,
   input  logic                dmem_valid,
   output logic                imem_req,
   output logic                dmem_req,
   output logic                dmem_we,
   output logic                fetch_instr,
   output logic                update_pc,
   output logic [PC_SEL_W-1:0] pc_sel,
   output logic                mem_func,
   output logic                mem_done,
   output logic                reg_we,
   output logic                halted,
   output logic                err,
   output logic [PERF_W-1:0]   cycle_cnt,
   output logic [PERF_W-1:0]   instret_cnt
);

   state_e                state_q, state_d;
   logic [WAIT_CNT_W-1:0] wait_q, wait_d;
   dec_t                  lat_q, lat_d;
   logic                  taken_q, taken_d;
   logic                  err_q, err_d;

   dec_t                  dec_c;
   logic                  wait_expired_c;
   logic                  hold_done_c;
   logic                  unused_instr_c;

   ctrl_decode u_decode (
      .opcode (instr[OPCODE_W-1:0]),
      .dec    (dec_c)
   );

   // Only the opcode field steers the controller; operand fields belong to the datapath.
   assign unused_instr_c = ^instr[31:OPCODE_W];

   // The wait counter doubles as the post-reset hold counter while in IDLE.
   assign wait_expired_c = (32'(wait_q) + 32'd1) >= MEM_TIMEOUT;
   assign hold_done_c    = (32'(wait_q) + 32'd1) >= RESET_HOLD;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= ST_IDLE;
         wait_q  <= '0;
         lat_q   <= '{cls: CLS_NONE, rf_we: 1'b0};
         taken_q <= 1'b0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         wait_q  <= wait_d;
         lat_q   <= lat_d;
         taken_q <= taken_d;
         err_q   <= err_d;
      end
   end

   always_comb begin
      state_d     = state_q;
      wait_d      = wait_q;
      lat_d       = lat_q;
      taken_d     = taken_q;
      err_d       = err_q;
      imem_req    = 1'b0;
      dmem_req    = 1'b0;
      dmem_we     = 1'b0;
      fetch_instr = 1'b0;
      update_pc   = 1'b0;
      pc_sel      = PC_SEL_DEF;
      mem_func    = 1'b0;
      mem_done    = 1'b0;
      reg_we      = 1'b0;
      halted      = 1'b0;

      case (state_q)
         ST_IDLE: begin
            if (hold_done_c) begin
               wait_d  = '0;
               state_d = ST_FETCH;
            end else begin
               wait_d = wait_q + WAIT_CNT_W'(1);
            end
         end

         ST_FETCH: begin
            imem_req = 1'b1;
            // A valid on the expiry cycle still completes the fetch.
            if (imem_valid) begin
               fetch_instr = 1'b1;
               wait_d      = '0;
               state_d     = ST_DECODE;
            end else if (wait_expired_c) begin
               wait_d  = '0;
               err_d   = 1'b1;
               state_d = ST_HALT;
            end else begin
               wait_d = wait_q + WAIT_CNT_W'(1);
            end
         end

         ST_DECODE: begin
            lat_d    = dec_c;
            mem_func = is_mem_class(dec_c.cls);
            state_d  = is_halt_class(dec_c.cls) ? ST_HALT : ST_EXEC;
         end

         ST_EXEC: begin
            taken_d  = branch_taken;
            mem_func = is_mem_class(lat_q.cls);
            state_d  = is_mem_class(lat_q.cls) ? ST_MEM : ST_WB;
         end

         ST_MEM: begin
            mem_func = 1'b1;
            dmem_req = 1'b1;
            dmem_we  = (lat_q.cls == CLS_STORE);
            if (dmem_valid) begin
               mem_done = 1'b1;
               wait_d   = '0;
               state_d  = ST_WB;
            end else if (wait_expired_c) begin
               wait_d  = '0;
               err_d   = 1'b1;
               state_d = ST_HALT;
            end else begin
               wait_d = wait_q + WAIT_CNT_W'(1);
            end
         end

         ST_WB: begin
            update_pc = 1'b1;
            reg_we    = lat_q.rf_we;
            case (lat_q.cls)
               CLS_JAL:    pc_sel = PC_SEL_JAL;
               CLS_JALR:   pc_sel = PC_SEL_JALR;
               CLS_BRANCH: pc_sel = taken_q ? PC_SEL_BRA : PC_SEL_DEF;
               default:    pc_sel = PC_SEL_DEF;
            endcase
            state_d = ST_FETCH;
         end

         ST_HALT: begin
            halted = 1'b1;
         end

         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   assign err = err_q;

`ifdef CTRL_PERF_EN
   logic [PERF_W-1:0] cycle_q, cycle_d;
   logic [PERF_W-1:0] instret_q, instret_d;

   // Free-running while the core is live; IDLE hold and HALT are not counted.
   always_comb begin
      cycle_d   = cycle_q;
      instret_d = instret_q;
      if ((state_q != ST_IDLE) && (state_q != ST_HALT)) begin
         cycle_d = cycle_q + PERF_W'(1);
      end
      if (update_pc) begin
         instret_d = instret_q + PERF_W'(1);
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         cycle_q   <= '0;
         instret_q <= '0;
      end else begin
         cycle_q   <= cycle_d;
         instret_q <= instret_d;
      end
   end

   assign cycle_cnt   = cycle_q;
   assign instret_cnt = instret_q;
`else
   assign cycle_cnt   = '0;
   assign instret_cnt = '0;
`endif

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Self-checking bench for multicycle_ctrl: per-instruction expected output schedules
// derived from the instruction's opcode and memory latencies, compared every cycle.
module tb_multicycle_ctrl;

   localparam int TO   = 4;
   localparam int HOLD = 2;
`ifdef CTRL_PERF_EN
   localparam bit PERF = 1'b1;
`else
   localparam bit PERF = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        reset;
   logic [31:0] instr;
   logic        branch_taken, imem_valid, dmem_valid;
   logic        imem_req, dmem_req, dmem_we, fetch_instr, update_pc;
   logic [2:0]  pc_sel;
   logic        mem_func, mem_done, reg_we, halted, err;
   logic [31:0] cycle_cnt, instret_cnt;

   always #5 clk = ~clk;

   multicycle_ctrl #(.MEM_TIMEOUT(TO), .RESET_HOLD(HOLD)) dut (
      .clk          (clk),
      .reset        (reset),
      .instr        (instr),
      .branch_taken (branch_taken),
      .imem_valid   (imem_valid),
      .dmem_valid   (dmem_valid),
      .imem_req     (imem_req),
      .dmem_req     (dmem_req),
      .dmem_we      (dmem_we),
      .fetch_instr  (fetch_instr),
      .update_pc    (update_pc),
      .pc_sel       (pc_sel),
      .mem_func     (mem_func),
      .mem_done     (mem_done),
      .reg_we       (reg_we),
      .halted       (halted),
      .err          (err),
      .cycle_cnt    (cycle_cnt),
      .instret_cnt  (instret_cnt)
   );

   typedef struct packed {
      logic        imem_req, dmem_req, dmem_we, fetch_instr, update_pc;
      logic [2:0]  pc_sel;
      logic        mem_func, mem_done, reg_we, halted, err;
      logic [31:0] c_cyc, c_ret;
   } obs_t;

   obs_t act, exp_o;
   bit   exp_on = 1'b0;
   int   n_checks = 0, n_fail = 0;
   int unsigned perf_cyc = 0, perf_ret = 0;
   logic hm = 1'b0, em = 1'b0;

   always_comb act = {imem_req, dmem_req, dmem_we, fetch_instr, update_pc, pc_sel,
                      mem_func, mem_done, reg_we, halted, err, cycle_cnt, instret_cnt};

   // Per-cycle comparison against the expected schedule.
   always @(negedge clk) begin
      if (exp_on) begin
         n_checks++;
         if (act !== exp_o) begin
            n_fail++;
            $display("FAIL outputs @%0t: got %h required %h", $time, act, exp_o);
         end
      end
   end

   // Event monitor for the literal spot checks.
   int tick = 0, fetch_tick = 0, upd_tick = 0;
   int n_imem = 0, n_dreq = 0, n_mf = 0, n_md = 0, n_dwe = 0;
   logic [2:0] last_psel = 3'b111;
   logic       last_rwe = 1'b0;
   always @(negedge clk) begin
      tick++;
      if (fetch_instr) fetch_tick = tick;
      if (update_pc) begin
         upd_tick  = tick;
         last_psel = pc_sel;
         last_rwe  = reg_we;
      end
      if (imem_req) n_imem++;
      if (dmem_req) n_dreq++;
      if (mem_func) n_mf++;
      if (mem_done) n_md++;
      if (dmem_we)  n_dwe++;
   end

   task automatic mon_clear();
      n_imem = 0; n_dreq = 0; n_mf = 0; n_md = 0; n_dwe = 0;
      last_psel = 3'b111; last_rwe = 1'b0;
   endtask

   task automatic chk(input string nm, input logic [79:0] got, input logic [79:0] want);
      n_checks++;
      if (got !== want) begin
         n_fail++;
         $display("FAIL %s: got %0h required %0h", nm, got, want);
      end
   endtask

   function automatic logic rb();
      return 1'($urandom_range(0, 1));
   endfunction

   // Instruction semantics as seen by the controller.
   task automatic classify(input logic [6:0] op, output logic mem, output logic st,
                           output logic br, output logic rwe, output logic hlt,
                           output logic [2:0] psel);
      mem = 0; st = 0; br = 0; rwe = 0; hlt = 0; psel = 3'b000;
      case (op)
         7'b0000011: begin mem = 1; rwe = 1; end
         7'b0100011: begin mem = 1; st = 1; end
         7'b1100011: br = 1;
         7'b1101111: begin rwe = 1; psel = 3'b100; end
         7'b1100111: begin rwe = 1; psel = 3'b010; end
         7'b0110011, 7'b0010011, 7'b0110111, 7'b0010111: rwe = 1;
         default: hlt = 1;
      endcase
   endtask

   // One clock cycle: drive inputs, publish expectation, advance.
   task automatic cyc(input obs_t e_in, input logic live, input logic [31:0] i_instr,
                      input logic iv, input logic dv, input logic bt);
      obs_t e;
      e = e_in;
      e.c_cyc = PERF ? perf_cyc : 32'd0;
      e.c_ret = PERF ? perf_ret : 32'd0;
      instr = i_instr; imem_valid = iv; dmem_valid = dv; branch_taken = bt;
      exp_o = e; exp_on = 1'b1;
      @(posedge clk); #1;
      if (live) perf_cyc++;
      if (e.update_pc) perf_ret++;
   endtask

   task automatic do_reset();
      obs_t e;
      exp_on = 1'b0;
      reset = 1'b1;
      instr = $urandom; imem_valid = rb(); dmem_valid = rb(); branch_taken = rb();
      @(posedge clk); #1;
      @(posedge clk); #1;
      chk("reset_outputs", 80'(act), 80'(0));
      reset = 1'b0;
      perf_cyc = 0; perf_ret = 0; hm = 1'b0; em = 1'b0;
      for (int k = 0; k < HOLD; k++) begin
         e = '0;
         cyc(e, 1'b0, $urandom, rb(), rb(), rb());
      end
   endtask

   task automatic halt_cycles(input int n);
      obs_t e;
      for (int k = 0; k < n; k++) begin
         e = '0; e.halted = 1'b1; e.err = em;
         cyc(e, 1'b0, $urandom, rb(), rb(), rb());
      end
   endtask

   // Full expected schedule of one instruction; delays >= TO model a memory timeout.
   task automatic run_instr(input logic [31:0] ins, input int idly, input int ddly,
                            input logic tk, input bit stop_in_mem);
      obs_t e;
      logic mem, st, br, rwe, hlt;
      logic [2:0] psel;
      classify(ins[6:0], mem, st, br, rwe, hlt, psel);
      for (int k = 0; k < idly && k < TO; k++) begin
         e = '0; e.imem_req = 1'b1;
         cyc(e, 1'b1, $urandom, 1'b0, rb(), rb());
      end
      if (idly >= TO) begin hm = 1'b1; em = 1'b1; return; end
      e = '0; e.imem_req = 1'b1; e.fetch_instr = 1'b1;
      cyc(e, 1'b1, ins, 1'b1, rb(), rb());
      e = '0; e.mem_func = mem;
      cyc(e, 1'b1, ins, rb(), rb(), rb());
      if (hlt) begin hm = 1'b1; em = 1'b0; return; end
      e = '0; e.mem_func = mem;
      cyc(e, 1'b1, mem ? ins : $urandom, rb(), rb(), tk);
      if (mem) begin
         if (stop_in_mem) return;
         for (int k = 0; k < ddly && k < TO; k++) begin
            e = '0; e.mem_func = 1'b1; e.dmem_req = 1'b1; e.dmem_we = st;
            cyc(e, 1'b1, ins, rb(), 1'b0, rb());
         end
         if (ddly >= TO) begin hm = 1'b1; em = 1'b1; return; end
         e = '0; e.mem_func = 1'b1; e.dmem_req = 1'b1; e.dmem_we = st; e.mem_done = 1'b1;
         cyc(e, 1'b1, ins, rb(), 1'b1, rb());
      end
      e = '0; e.update_pc = 1'b1; e.reg_we = rwe;
      e.pc_sel = br ? (tk ? 3'b001 : 3'b000) : psel;
      cyc(e, 1'b1, $urandom, rb(), rb(), rb());
   endtask

   logic [6:0] legal_ops [10];
   initial begin
      legal_ops = '{7'b0000011, 7'b0100011, 7'b1100011, 7'b1101111, 7'b1100111,
                    7'b0110011, 7'b0010011, 7'b0110111, 7'b0010111, 7'b0010011};
   end

   task automatic random_run(input int n);
      logic [31:0] r;
      for (int k = 0; k < n; k++) begin
         r = $urandom;
         run_instr({r[31:7], legal_ops[$urandom_range(0, 9)]},
                   int'($urandom_range(0, 3)), int'($urandom_range(0, 3)), rb(), 1'b0);
      end
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      reset = 1'b1; instr = '0; imem_valid = 0; dmem_valid = 0; branch_taken = 0;
      do_reset();

      // Three ADDIs, instruction memory answering one cycle after the request.
      for (int k = 0; k < 3; k++) run_instr(32'h0010_0093, 1, 0, 1'b0, 1'b0);
      chk("addi_fetch_to_update", 80'(upd_tick - fetch_tick), 80'(3));
      chk("addi_pc_sel_rwe", 80'({last_psel, last_rwe}), 80'(4'b0001));
      chk("instret_after_3", 80'(instret_cnt), PERF ? 80'(3) : 80'(0));
      chk("cycles_after_3", 80'(cycle_cnt), PERF ? 80'(15) : 80'(0));

      run_instr(32'h0000_0463, 0, 0, 1'b1, 1'b0);
      chk("beq_taken", 80'({last_psel, last_rwe}), 80'(4'b0010));
      run_instr(32'h0000_0463, 0, 0, 1'b0, 1'b0);
      chk("beq_not_taken", 80'({last_psel, last_rwe}), 80'(4'b0000));

      mon_clear();
      run_instr(32'h0000_A103, 0, 3, 1'b0, 1'b0);
      chk("lw_counts", 80'({8'(n_dreq), 8'(n_mf), 8'(n_md), 8'(n_dwe)}), 80'(32'h04_06_01_00));
      chk("lw_rwe", 80'(last_rwe), 80'(1));
      mon_clear();
      run_instr(32'h0000_A023, 0, 0, 1'b0, 1'b0);
      chk("sw_we_rwe", 80'({8'(n_dwe), 7'd0, last_rwe}), 80'(16'h0100));

      run_instr(32'h0080_00EF, 0, 0, 1'b0, 1'b0);
      chk("jal", 80'({last_psel, last_rwe}), 80'(4'b1001));
      run_instr(32'h0000_80E7, 0, 0, 1'b0, 1'b0);
      chk("jalr", 80'({last_psel, last_rwe}), 80'(4'b0101));

      // Valid arriving on the cycle the wait counter expires.
      run_instr(32'h0010_0093, TO - 1, 0, 1'b0, 1'b0);
      run_instr(32'h0000_A103, 0, TO - 1, 1'b0, 1'b0);
      random_run(40);

      // Instruction memory never answers.
      mon_clear();
      run_instr(32'h0010_0093, 99, 0, 1'b0, 1'b0);
      halt_cycles(6);
      chk("imem_timeout", 80'({8'(n_imem), 3'd0, halted, 3'd0, err}), 80'(24'h04_1_1));

      do_reset();
      random_run(5);
      run_instr(32'h0000_A103, 0, 99, 1'b0, 1'b0);
      halt_cycles(4);
      chk("dmem_timeout", 80'({halted, err}), 80'(2'b11));

      do_reset();
      run_instr(32'h0000_0073, 0, 0, 1'b0, 1'b0);
      halt_cycles(4);
      chk("ecall_halt", 80'({halted, err}), 80'(2'b10));

      do_reset();
      run_instr(32'h0000_007F, 1, 0, 1'b0, 1'b0);
      halt_cycles(3);
      chk("illegal_halt", 80'({halted, err}), 80'(2'b10));

      // Asynchronous reset in the middle of a data access.
      do_reset();
      random_run(3);
      run_instr(32'h0000_A023, 0, 0, 1'b0, 1'b1);
      exp_on = 1'b0; dmem_valid = 1'b0;
      #1;
      chk("pre_abort_mem", 80'({mem_func, dmem_req, dmem_we}), 80'(3'b111));
      reset = 1'b1;
      #1;
      chk("abort_outputs_zero", 80'(act), 80'(0));
      do_reset();
      random_run(10);

      exp_on = 1'b0;
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
